wl_demux_dac_ctrl: RTL and testbench

Parametrised successor to the fixed-latency DAC controller, matching the analog team's grouped WL de-mux (NUM_GROUPS latches of GROUP_W bits).
Captures a WL bitmap from cim_array_ctrl and serialises it group by group onto a narrow bus, with one latch strobe per group. It then waits a runtime-programmable settle time and, optionally, a ready handshake with timeout before pulsing completion.
Sits between cim_array_ctrl and the CIM macro / cim_macro_blackbox.

---
 rtl/wl_demux_dac_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_wl_demux_dac_ctrl.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wl_demux_dac_ctrl.sv
// ---------------------------------------------------------------------------
// wl_demux_dac_ctrl
//
// Purpose:
//   Takes a WL activation bitmap from cim_array_ctrl and pushes it to the
//   analog grouped WL de-mux one GROUP_W-bit slice at a time. Each slice is
//   accompanied by a one-cycle latch strobe. An optional number of idle cycles
//   can be inserted between consecutive latches. After the last group has
//   latched, the full bitmap is presented on wl_spike for the behavioural
//   model. The block then waits a programmable settle time. If the handshake
//   is enabled, it also waits for dac_ready, bounded by a timeout. Finally it
//   pulses completion.
//
// Ports:
//   clk            - clock
//   rst_n          - synchronous, active-low reset
//   wl_bitmap      - WL activation map for the current bit-plane
//   wl_valid_pulse - one-cycle start request
//   cfg_latency    - settle cycles after the last group latch (0 allowed)
//   cfg_group_gap  - idle cycles between consecutive group latches (0 allowed)
//   cfg_hs_en      - wait for dac_ready after settle when 1
//   dac_ready      - analog ready, only looked at while waiting for it
//   err_clr        - clears both sticky error flags
//   wl_group_sel   - index of the group currently driven
//   wl_group_data  - bitmap slice belonging to wl_group_sel
//   wl_latch       - one-cycle strobe: analog latches the current group
//   wl_spike       - full captured bitmap, updated together with dac_valid
//   dac_valid      - one-cycle pulse marking a wl_spike update
//   dac_done_pulse - one-cycle completion pulse
//   busy           - a sequence is in progress
//   overrun_err    - sticky: start request arrived while busy
//   timeout_err    - sticky: dac_ready never arrived within the timeout
// ---------------------------------------------------------------------------
module wl_demux_dac_ctrl #(
  parameter int NUM_INPUTS     = 64,
  parameter int GROUP_W        = 8,
  parameter int LAT_W          = 8,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int NUM_GROUPS    = NUM_INPUTS / GROUP_W,
  localparam int SEL_W         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_INPUTS-1:0] wl_bitmap,
  input  logic                  wl_valid_pulse,
  input  logic [LAT_W-1:0]      cfg_latency,
  input  logic [LAT_W-1:0]      cfg_group_gap,
  input  logic                  cfg_hs_en,
  input  logic                  dac_ready,
  input  logic                  err_clr,
  output logic [SEL_W-1:0]      wl_group_sel,
  output logic [GROUP_W-1:0]    wl_group_data,
  output logic                  wl_latch,
  output logic [NUM_INPUTS-1:0] wl_spike,
  output logic                  dac_valid,
  output logic                  dac_done_pulse,
  output logic                  busy,
  output logic                  overrun_err,
  output logic                  timeout_err
);

  // The timeout counter must reach TIMEOUT_CYCLES-1. That value can exceed
  // the LAT_W range, so the counter gets its own width.
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [SEL_W-1:0] LAST_GRP = SEL_W'(NUM_GROUPS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    GAP      = 3'd2,
    SETTLE   = 3'd3,
    WAIT_RDY = 3'd4
  } state_t;

  state_t                state_q, state_n;
  logic [SEL_W-1:0]      grp_q, grp_n;
  logic [LAT_W-1:0]      cnt_q, cnt_n;
  logic [TO_W-1:0]       tcnt_q, tcnt_n;

  logic [NUM_INPUTS-1:0] bitmap_q;
  logic [LAT_W-1:0]      lat_q;
  logic [LAT_W-1:0]      gap_q;
  logic                  hs_q;

  logic                  accept;
  logic                  overrun_ev;
  logic                  valid_ev;
  logic                  done_ev;
  logic                  timeout_ev;

  logic [NUM_INPUTS-1:0] src_bitmap;
  logic                  latch_n;
  logic [SEL_W-1:0]      sel_n;
  logic [GROUP_W-1:0]    data_n;
  logic [NUM_INPUTS-1:0] spike_n;

  assign busy       = (state_q != IDLE);
  assign accept     = (state_q == IDLE) && wl_valid_pulse;
  assign overrun_ev = (state_q != IDLE) && wl_valid_pulse;

  // On the accept cycle the bitmap has not been registered yet. In that cycle
  // the first slice comes straight from the input; in all later cycles it
  // comes from the captured copy.
  assign src_bitmap = accept ? wl_bitmap : bitmap_q;

  // State register, working counters and the configuration captured at
  // accept. Once a sequence has started, it ignores any further changes on
  // the cfg_* inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grp_q    <= '0;
      cnt_q    <= '0;
      tcnt_q   <= '0;
      bitmap_q <= '0;
      lat_q    <= '0;
      gap_q    <= '0;
      hs_q     <= 1'b0;
    end else begin
      state_q <= state_n;
      grp_q   <= grp_n;
      cnt_q   <= cnt_n;
      tcnt_q  <= tcnt_n;
      if (accept) begin
        bitmap_q <= wl_bitmap;
        lat_q    <= cfg_latency;
        gap_q    <= cfg_group_gap;
        hs_q     <= cfg_hs_en;
      end
    end
  end

  // Next-state logic.
  // GAP and SETTLE load their counter with the full cycle count on entry and
  // leave when it reads 1. Because of this, the counter never decrements
  // below 1, and the maximum LAT_W value is honoured exactly. Every entry
  // into LOAD is a latch cycle for group grp_n. The events valid_ev, done_ev
  // and timeout_ev mark the transitions that the output logic turns into
  // registered pulses.
  always_comb begin
    state_n    = state_q;
    grp_n      = grp_q;
    cnt_n      = cnt_q;
    tcnt_n     = tcnt_q;
    valid_ev   = 1'b0;
    done_ev    = 1'b0;
    timeout_ev = 1'b0;
    case (state_q)
      IDLE: begin
        if (wl_valid_pulse) begin
          state_n = LOAD;
          grp_n   = '0;
        end
      end
      LOAD: begin
        if (grp_q == LAST_GRP) begin
          valid_ev = 1'b1;
          if (lat_q != '0) begin
            state_n = SETTLE;
            cnt_n   = lat_q;
          end else if (hs_q) begin
            state_n = WAIT_RDY;
            tcnt_n  = '0;
          end else begin
            state_n = IDLE;
            done_ev = 1'b1;
          end
        end else if (gap_q != '0) begin
          state_n = GAP;
          cnt_n   = gap_q;
        end else begin
          grp_n = grp_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == LAT_W'(1)) begin
          state_n = LOAD;
          grp_n   = grp_q + 1'b1;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == LAT_W'(1)) begin
          if (hs_q) begin
            state_n = WAIT_RDY;
            tcnt_n  = '0;
          end else begin
            state_n = IDLE;
            done_ev = 1'b1;
          end
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      WAIT_RDY: begin
        // A ready seen in the last permitted cycle still counts as a normal
        // handshake, so it takes priority over the timeout.
        if (dac_ready) begin
          state_n = IDLE;
          done_ev = 1'b1;
        end else if (tcnt_q == TO_LAST) begin
          state_n    = IDLE;
          done_ev    = 1'b1;
          timeout_ev = 1'b1;
        end else begin
          tcnt_n = tcnt_q + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Output logic: computes the values that the output registers take at the
  // next edge. Select and data change only on a latch cycle. Between latches
  // they hold, so the analog side sees a stable bus.
  always_comb begin
    latch_n = 1'b0;
    sel_n   = wl_group_sel;
    data_n  = wl_group_data;
    spike_n = wl_spike;
    if (state_n == LOAD) begin
      latch_n = 1'b1;
      sel_n   = grp_n;
      data_n  = src_bitmap[int'(grp_n)*GROUP_W +: GROUP_W];
    end
    if (valid_ev) begin
      spike_n = bitmap_q;
    end
  end

  // Registered outputs. Because of these registers, every strobe appears one
  // cycle after the transition that caused it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wl_latch       <= 1'b0;
      wl_group_sel   <= '0;
      wl_group_data  <= '0;
      wl_spike       <= '0;
      dac_valid      <= 1'b0;
      dac_done_pulse <= 1'b0;
    end else begin
      wl_latch       <= latch_n;
      wl_group_sel   <= sel_n;
      wl_group_data  <= data_n;
      wl_spike       <= spike_n;
      dac_valid      <= valid_ev;
      dac_done_pulse <= done_ev;
    end
  end

  // Sticky error flags. If a new error arrives in the same cycle as err_clr,
  // the new error wins, so no event is ever lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      overrun_err <= overrun_ev | (overrun_err & ~err_clr);
      timeout_err <= timeout_ev | (timeout_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_wl_demux_dac_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wl_demux_dac_ctrl
//
// Directed bench for wl_demux_dac_ctrl. The DUT is built with
// TIMEOUT_CYCLES=4 so that the timeout path is reached quickly. Cycle Tn is
// the n-th cycle after the cycle T0 in which the start pulse is driven.
// Inputs change 1 time unit after a rising edge, and outputs are sampled at
// the same point.
// ---------------------------------------------------------------------------
module tb_wl_demux_dac_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] wl_bitmap;
  logic        wl_valid_pulse;
  logic [7:0]  cfg_latency;
  logic [7:0]  cfg_group_gap;
  logic        cfg_hs_en;
  logic        dac_ready;
  logic        err_clr;
  logic [2:0]  wl_group_sel;
  logic [7:0]  wl_group_data;
  logic        wl_latch;
  logic [63:0] wl_spike;
  logic        dac_valid;
  logic        dac_done_pulse;
  logic        busy;
  logic        overrun_err;
  logic        timeout_err;

  int vectors = 0;
  int errors  = 0;

  wl_demux_dac_ctrl #(
    .NUM_INPUTS    (64),
    .GROUP_W       (8),
    .LAT_W         (8),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wl_bitmap     (wl_bitmap),
    .wl_valid_pulse(wl_valid_pulse),
    .cfg_latency   (cfg_latency),
    .cfg_group_gap (cfg_group_gap),
    .cfg_hs_en     (cfg_hs_en),
    .dac_ready     (dac_ready),
    .err_clr       (err_clr),
    .wl_group_sel  (wl_group_sel),
    .wl_group_data (wl_group_data),
    .wl_latch      (wl_latch),
    .wl_spike      (wl_spike),
    .dac_valid     (dac_valid),
    .dac_done_pulse(dac_done_pulse),
    .busy          (busy),
    .overrun_err   (overrun_err),
    .timeout_err   (timeout_err)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running exp finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Move to 1 unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    wl_valid_pulse = 1'b1;
    wl_bitmap      = '1;
    cfg_latency    = 8'd5;
    cfg_group_gap  = 8'd5;
    cfg_hs_en      = 1'b1;
    dac_ready      = 1'b1;
    err_clr        = 1'b0;
    step();
    step();
    vectors++;
    if ({wl_latch, dac_valid, dac_done_pulse, busy, overrun_err, timeout_err} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_strobes got %b exp 000000",
               {wl_latch, dac_valid, dac_done_pulse, busy, overrun_err, timeout_err});
    end
    vectors++;
    if (wl_group_sel !== 3'd0 || wl_group_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_bus got sel %0d data %h exp 0 00", wl_group_sel, wl_group_data);
    end
    vectors++;
    if (wl_spike !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_spike got %h exp 0", wl_spike);
    end
    wl_valid_pulse = 1'b0;
    dac_ready      = 1'b0;
    rst_n          = 1'b1;
    step();
    vectors++;
    if (busy !== 1'b0 || wl_latch !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release got busy %b latch %b exp 0 0", busy, wl_latch);
    end
  endtask

  // G=0, L=3, no handshake.
  task automatic test_basic();
    logic [63:0] bm;
    logic e_latch, e_valid, e_done, e_busy;
    bm             = 64'h0123_4567_89AB_CDEF;
    wl_bitmap      = bm;
    cfg_group_gap  = 8'd0;
    cfg_latency    = 8'd3;
    cfg_hs_en      = 1'b0;
    wl_valid_pulse = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step();
      wl_valid_pulse = 1'b0;
      e_latch = (k <= 8);
      e_valid = (k == 9);
      e_done  = (k == 12);
      e_busy  = (k <= 11);
      vectors++;
      if ({wl_latch, dac_valid, dac_done_pulse, busy} !== {e_latch, e_valid, e_done, e_busy}) begin
        errors++;
        $display("[TB] FAIL basic_strobes T%0d latch/valid/done/busy got %b%b%b%b exp %b%b%b%b",
                 k, wl_latch, dac_valid, dac_done_pulse, busy, e_latch, e_valid, e_done, e_busy);
      end
      if (e_latch) begin
        vectors++;
        if (wl_group_sel !== 3'(k-1) || wl_group_data !== bm[(k-1)*8 +: 8]) begin
          errors++;
          $display("[TB] FAIL basic_group T%0d got sel %0d data %h exp %0d %h",
                   k, wl_group_sel, wl_group_data, k-1, bm[(k-1)*8 +: 8]);
        end
      end
      vectors++;
      if (wl_spike !== ((k >= 9) ? bm : 64'h0)) begin
        errors++;
        $display("[TB] FAIL basic_spike T%0d got %h exp %h", k, wl_spike, (k >= 9) ? bm : 64'h0);
      end
    end
  endtask

  // G=2, L=0: latches every third cycle, with valid and done together.
  task automatic test_gap();
    logic [63:0] bm;
    logic e_latch, e_valid, e_done, e_busy;
    int   e_sel;
    bm             = 64'hFEDC_BA98_7654_3210;
    wl_bitmap      = bm;
    cfg_group_gap  = 8'd2;
    cfg_latency    = 8'd0;
    cfg_hs_en      = 1'b0;
    wl_valid_pulse = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      wl_valid_pulse = 1'b0;
      e_latch = (k <= 22) && ((k - 1) % 3 == 0);
      e_valid = (k == 23);
      e_done  = (k == 23);
      e_busy  = (k <= 22);
      vectors++;
      if ({wl_latch, dac_valid, dac_done_pulse, busy} !== {e_latch, e_valid, e_done, e_busy}) begin
        errors++;
        $display("[TB] FAIL gap_strobes T%0d latch/valid/done/busy got %b%b%b%b exp %b%b%b%b",
                 k, wl_latch, dac_valid, dac_done_pulse, busy, e_latch, e_valid, e_done, e_busy);
      end
      if (k <= 22) begin
        e_sel = (k - 1) / 3;
        vectors++;
        if (wl_group_sel !== 3'(e_sel) || wl_group_data !== bm[e_sel*8 +: 8]) begin
          errors++;
          $display("[TB] FAIL gap_group_hold T%0d got sel %0d data %h exp %0d %h",
                   k, wl_group_sel, wl_group_data, e_sel, bm[e_sel*8 +: 8]);
        end
      end
      if (k >= 23) begin
        vectors++;
        if (wl_spike !== bm) begin
          errors++;
          $display("[TB] FAIL gap_spike T%0d got %h exp %h", k, wl_spike, bm);
        end
      end
    end
  endtask

  // Handshake with L=3, so WAIT_RDY starts at T12. A ready pulse during LOAD
  // (T5) and one during SETTLE (T10) must be ignored. Ready at T15, the last
  // cycle before the 4-cycle timeout, must give done at T16 with no error.
  task automatic test_handshake();
    logic e_valid, e_done, e_busy;
    wl_bitmap      = 64'h1111_2222_3333_4444;
    cfg_group_gap  = 8'd0;
    cfg_latency    = 8'd3;
    cfg_hs_en      = 1'b1;
    dac_ready      = 1'b0;
    wl_valid_pulse = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step();
      wl_valid_pulse = 1'b0;
      dac_ready      = (k == 5) || (k == 10) || (k == 15);
      e_valid = (k == 9);
      e_done  = (k == 16);
      e_busy  = (k <= 15);
      vectors++;
      if ({dac_valid, dac_done_pulse, busy, timeout_err} !== {e_valid, e_done, e_busy, 1'b0}) begin
        errors++;
        $display("[TB] FAIL hs_ready T%0d valid/done/busy/tmo got %b%b%b%b exp %b%b%b0",
                 k, dac_valid, dac_done_pulse, busy, timeout_err, e_valid, e_done, e_busy);
      end
    end
    dac_ready = 1'b0;
  endtask

  // Handshake with L=1 and ready held low. WAIT_RDY covers T10..T13; the
  // forced done comes at T14 and sets timeout_err, which err_clr at T18
  // clears.
  task automatic test_timeout();
    logic e_done, e_busy, e_tmo;
    wl_bitmap      = 64'h5555_AAAA_5555_AAAA;
    cfg_group_gap  = 8'd0;
    cfg_latency    = 8'd1;
    cfg_hs_en      = 1'b1;
    dac_ready      = 1'b0;
    wl_valid_pulse = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      wl_valid_pulse = 1'b0;
      err_clr        = (k == 18);
      e_done = (k == 14);
      e_busy = (k <= 13);
      e_tmo  = (k >= 14) && (k <= 18);
      vectors++;
      if ({dac_done_pulse, busy, timeout_err} !== {e_done, e_busy, e_tmo}) begin
        errors++;
        $display("[TB] FAIL timeout T%0d done/busy/tmo got %b%b%b exp %b%b%b",
                 k, dac_done_pulse, busy, timeout_err, e_done, e_busy, e_tmo);
      end
    end
    err_clr = 1'b0;
  endtask

  // Pulse at T5 is ignored and sets overrun. A pulse in the done cycle (T12)
  // starts the next sequence with no bubble. At T15, a new overrun arrives
  // together with err_clr, and the flag stays set. err_clr alone at T17
  // clears it.
  task automatic test_back_to_back();
    logic [63:0] bm1, bm2;
    logic e_latch, e_valid, e_done, e_busy, e_ov;
    logic [7:0] e_data;
    bm1            = 64'h0F1E_2D3C_4B5A_6978;
    bm2            = 64'hC3C3_9696_3C3C_6969;
    wl_bitmap      = bm1;
    cfg_group_gap  = 8'd0;
    cfg_latency    = 8'd3;
    cfg_hs_en      = 1'b0;
    err_clr        = 1'b0;
    wl_valid_pulse = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      wl_valid_pulse = (k == 5) || (k == 12) || (k == 15);
      err_clr        = (k == 15) || (k == 17);
      if (k == 5) begin
        wl_bitmap   = 64'hDEAD_BEEF_DEAD_BEEF;
        cfg_latency = 8'd0;
      end
      if (k == 12) wl_bitmap = bm2;
      e_latch = (k <= 8) || (k >= 13 && k <= 20);
      e_valid = (k == 9) || (k == 21);
      e_done  = (k == 12) || (k == 21);
      e_busy  = (k <= 11) || (k >= 13 && k <= 20);
      e_ov    = (k >= 6) && (k <= 17);
      vectors++;
      if ({wl_latch, dac_valid, dac_done_pulse, busy, overrun_err} !==
          {e_latch, e_valid, e_done, e_busy, e_ov}) begin
        errors++;
        $display("[TB] FAIL b2b_strobes T%0d latch/valid/done/busy/ovr got %b%b%b%b%b exp %b%b%b%b%b",
                 k, wl_latch, dac_valid, dac_done_pulse, busy, overrun_err,
                 e_latch, e_valid, e_done, e_busy, e_ov);
      end
      if (e_latch) begin
        e_data = (k <= 8) ? bm1[(k-1)*8 +: 8] : bm2[(k-13)*8 +: 8];
        vectors++;
        if (wl_group_sel !== ((k <= 8) ? 3'(k-1) : 3'(k-13)) || wl_group_data !== e_data) begin
          errors++;
          $display("[TB] FAIL b2b_group T%0d got sel %0d data %h exp data %h",
                   k, wl_group_sel, wl_group_data, e_data);
        end
      end
      if (k >= 9) begin
        vectors++;
        if (wl_spike !== ((k >= 21) ? bm2 : bm1)) begin
          errors++;
          $display("[TB] FAIL b2b_spike T%0d got %h exp %h", k, wl_spike, (k >= 21) ? bm2 : bm1);
        end
      end
    end
    wl_valid_pulse = 1'b0;
    err_clr        = 1'b0;
  endtask

  // Start with G=1, L=2, no handshake. During GAP at T2, switch the cfg inputs
  // to G=0, L=0, hs=1. Timing must still follow the captured values: valid at
  // T16 and done at T18.
  task automatic test_cfg_change();
    logic [63:0] bm;
    logic e_latch, e_valid, e_done, e_busy;
    int   e_sel;
    bm             = 64'hA5A5_5A5A_0F0F_F0F0;
    wl_bitmap      = bm;
    cfg_group_gap  = 8'd1;
    cfg_latency    = 8'd2;
    cfg_hs_en      = 1'b0;
    dac_ready      = 1'b0;
    wl_valid_pulse = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      step();
      wl_valid_pulse = 1'b0;
      if (k == 2) begin
        cfg_group_gap = 8'd0;
        cfg_latency   = 8'd0;
        cfg_hs_en     = 1'b1;
      end
      e_latch = (k <= 15) && (k % 2 == 1);
      e_valid = (k == 16);
      e_done  = (k == 18);
      e_busy  = (k <= 17);
      vectors++;
      if ({wl_latch, dac_valid, dac_done_pulse, busy} !== {e_latch, e_valid, e_done, e_busy}) begin
        errors++;
        $display("[TB] FAIL cfg_strobes T%0d latch/valid/done/busy got %b%b%b%b exp %b%b%b%b",
                 k, wl_latch, dac_valid, dac_done_pulse, busy, e_latch, e_valid, e_done, e_busy);
      end
      if (k <= 15) begin
        e_sel = (k - 1) / 2;
        vectors++;
        if (wl_group_sel !== 3'(e_sel) || wl_group_data !== bm[e_sel*8 +: 8]) begin
          errors++;
          $display("[TB] FAIL cfg_group T%0d got sel %0d data %h exp %0d %h",
                   k, wl_group_sel, wl_group_data, e_sel, bm[e_sel*8 +: 8]);
        end
      end
    end
  endtask

  // Reset sampled at the end of T6 (mid-LOAD). From T7 everything is zero and
  // no done follows. After release, a fresh sequence with G=1, L=0 runs
  // normally.
  task automatic test_reset_mid();
    logic [63:0] bm1, bm3;
    logic e_latch, e_valid, e_done, e_busy;
    bm1            = 64'h0123_4567_89AB_CDEF;
    bm3            = 64'h8040_2010_0804_0201;
    wl_bitmap      = bm1;
    cfg_group_gap  = 8'd0;
    cfg_latency    = 8'd3;
    cfg_hs_en      = 1'b0;
    wl_valid_pulse = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      wl_valid_pulse = 1'b0;
      rst_n          = (k != 6);
      if (k <= 6) begin
        vectors++;
        if (wl_latch !== 1'b1 || busy !== 1'b1 || wl_group_sel !== 3'(k-1)) begin
          errors++;
          $display("[TB] FAIL rstmid_pre T%0d got latch %b busy %b sel %0d exp 1 1 %0d",
                   k, wl_latch, busy, wl_group_sel, k-1);
        end
      end else begin
        vectors++;
        if ({wl_latch, dac_valid, dac_done_pulse, busy, overrun_err, timeout_err} !== 6'b0 ||
            wl_group_sel !== 3'd0 || wl_group_data !== 8'h00 || wl_spike !== 64'h0) begin
          errors++;
          $display("[TB] FAIL rstmid_cleared T%0d got strobes %b sel %0d data %h spike %h exp all zero",
                   k, {wl_latch, dac_valid, dac_done_pulse, busy, overrun_err, timeout_err},
                   wl_group_sel, wl_group_data, wl_spike);
        end
      end
    end
    wl_bitmap      = bm3;
    cfg_group_gap  = 8'd1;
    cfg_latency    = 8'd0;
    wl_valid_pulse = 1'b1;
    for (int j = 1; j <= 17; j++) begin
      step();
      wl_valid_pulse = 1'b0;
      e_latch = (j <= 15) && (j % 2 == 1);
      e_valid = (j == 16);
      e_done  = (j == 16);
      e_busy  = (j <= 15);
      vectors++;
      if ({wl_latch, dac_valid, dac_done_pulse, busy} !== {e_latch, e_valid, e_done, e_busy}) begin
        errors++;
        $display("[TB] FAIL rstmid_after T%0d latch/valid/done/busy got %b%b%b%b exp %b%b%b%b",
                 j, wl_latch, dac_valid, dac_done_pulse, busy, e_latch, e_valid, e_done, e_busy);
      end
      if (e_latch) begin
        vectors++;
        if (wl_group_sel !== 3'((j-1)/2) || wl_group_data !== bm3[((j-1)/2)*8 +: 8]) begin
          errors++;
          $display("[TB] FAIL rstmid_group T%0d got sel %0d data %h exp %0d %h",
                   j, wl_group_sel, wl_group_data, (j-1)/2, bm3[((j-1)/2)*8 +: 8]);
        end
      end
      vectors++;
      if (wl_spike !== ((j >= 16) ? bm3 : 64'h0)) begin
        errors++;
        $display("[TB] FAIL rstmid_spike T%0d got %h exp %h", j, wl_spike, (j >= 16) ? bm3 : 64'h0);
      end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    wl_bitmap      = '0;
    wl_valid_pulse = 1'b0;
    cfg_latency    = '0;
    cfg_group_gap  = '0;
    cfg_hs_en      = 1'b0;
    dac_ready      = 1'b0;
    err_clr        = 1'b0;
    test_reset();
    test_basic();
    test_gap();
    test_handshake();
    test_timeout();
    test_back_to_back();
    test_cfg_change();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
